ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  - Shares the single data RAM port (ram: read_en/write_en/addr_i/write_data_i/read_data_o/dmem_error_o)
//    between two requesters: port 0 (load/store unit) and port 1 (fetch / debug loader).
//  - Accepts one request at a time, sequences the RAM access and returns read data, completion and error
//    to the owning port. Sits between the core memory stage and the ram instance.
// PARAMETERS
//  ADDR_W      64  address width, requester and RAM side
//  DATA_W      64  data width
//  ALIGN_BITS  3   low address bits that must be zero (8-byte words); 0 disables the check
// PORTS
//  clk_i            in   1       clock, all state on rising edge
//  rst_n_i          in   1       reset, asynchronous, active-low
//  mX_req_i         in   1       request valid, X=0,1; held with cmd fields until accepted
//  mX_we_i          in   1       1=write, 0=read
//  mX_addr_i        in   ADDR_W  byte address
//  mX_wdata_i       in   DATA_W  write data
//  mX_gnt_o         out  1       request accepted at this edge (req & gnt)
//  mX_rvalid_o      out  1       one-cycle completion pulse (reads and writes)
//  mX_rdata_o       out  DATA_W  read data, valid with rvalid; 0 for writes/errors
//  mX_err_o         out  1       error flag, valid with rvalid
//  ram_read_en_o    out  1       to ram read_en
//  ram_write_en_o   out  1       to ram write_en
//  ram_addr_o       out  ADDR_W  to ram addr_i
//  ram_wdata_o      out  DATA_W  to ram write_data_i
//  ram_rdata_i      in   DATA_W  from ram read_data_o, sampled one cycle after enable
//  ram_err_i        in   1       from ram dmem_error_o, sampled with ram_rdata_i
//  busy_o           out  1       FSM not in IDLE
// BEHAVIOUR
//  - Reset: every output 0, FSM=IDLE, latched cmd regs 0, last-grant pointer=port 1 (so port 0 wins first).
//  - FSM IDLE -> ACCESS -> RESP -> IDLE; one transaction per 3 cycles max.
//  - IDLE: if any req, combinationally assert gnt to exactly one winner; at the edge latch we/addr/wdata/owner.
//    Misaligned addr (addr[ALIGN_BITS-1:0]!=0): go directly to RESP with err, RAM never enabled.
//  - ACCESS: ram_addr_o/ram_wdata_o from latched regs; exactly one of ram_read_en_o/ram_write_en_o high for
//    this single cycle; both 0 in every other state.
//  - RESP: owner's rvalid=1 for one cycle; rdata=ram_rdata_i (reads, no error) else 0; err=ram_err_i|misalign.
//    Non-owner rvalid stays 0. Returns to IDLE; new grant possible the following cycle.
//  - gnt only asserted in IDLE; requests arriving in ACCESS/RESP wait (req stays high, no gnt).
//  - Both req in IDLE: winner per arbitration mode (CONFIGURATION); loser keeps req, served next IDLE.
//  - req dropped before gnt: silently withdrawn, no response.
//  - ram_addr_o/ram_wdata_o hold last latched values outside ACCESS (no toggling), enables gate the RAM.
//  - Reset asserted mid-transaction: immediate return to IDLE, in-flight access dropped, no rvalid emitted,
//    RAM enables drop asynchronously.
// CONFIGURATION
//  RAM_ARB_RR_EN defined: round-robin; on contention grant the port not granted last; pointer updates on
//    every grant (including misaligned ones).
//  RAM_ARB_RR_EN undefined: fixed priority, port 0 always wins contention; pointer logic absent.
// TESTING
//  1 Reset: rst_n_i=0 mid-run -> all outputs 0, busy_o=0 same cycle, no rvalid after release.
//  2 m0 write addr=0x10 data=0xDEAD_BEEF, then m0 read 0x10 -> ram_write_en_o 1 cycle in ACCESS, then
//    m0_rvalid=1, m0_rdata=0xDEAD_BEEF, err=0; gnt-to-rvalid = 2 cycles.
//  3 m0 and m1 both read (0x08, 0x18) in same IDLE cycle: fixed mode -> m0 first, m1 granted 3 cycles later;
//    RR mode with last grant=m0 -> m1 first.
//  4 RR starvation: both req held continuously for 8 transactions -> grants alternate m0,m1,m0,... (4 each).
//  5 Misaligned read addr=0x0C -> no RAM enable ever, rvalid next cycle after gnt with err=1, rdata=0.
//  6 ram_err_i=1 during RESP for m1 read -> m1_err_o=1, m1_rdata_o=0, m0 outputs unaffected.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
//  Bundles the two requester channels (m0 = load/store unit, m1 = fetch /
//  debug loader) and the single RAM port that ram_arbiter multiplexes.
//  Signal suffixes follow the arbiter's point of view: _i is driven into the
//  arbiter, _o is driven by it.
//  Modports:
//   slave  - the arbiter: takes requests and RAM read data, drives grants,
//            responses and the RAM command.
//   master - the surroundings (requesters plus RAM): the mirror image.
interface ram_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              m0_req_i;
   logic              m0_we_i;
   logic [ADDR_W-1:0] m0_addr_i;
   logic [DATA_W-1:0] m0_wdata_i;
   logic              m0_gnt_o;
   logic              m0_rvalid_o;
   logic [DATA_W-1:0] m0_rdata_o;
   logic              m0_err_o;

   logic              m1_req_i;
   logic              m1_we_i;
   logic [ADDR_W-1:0] m1_addr_i;
   logic [DATA_W-1:0] m1_wdata_i;
   logic              m1_gnt_o;
   logic              m1_rvalid_o;
   logic [DATA_W-1:0] m1_rdata_o;
   logic              m1_err_o;

   logic              ram_read_en_o;
   logic              ram_write_en_o;
   logic [ADDR_W-1:0] ram_addr_o;
   logic [DATA_W-1:0] ram_wdata_o;
   logic [DATA_W-1:0] ram_rdata_i;
   logic              ram_err_i;

   modport slave (
      input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
      output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
      input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
      output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
      output ram_read_en_o, ram_write_en_o, ram_addr_o, ram_wdata_o,
      input  ram_rdata_i, ram_err_i
   );

   modport master (
      output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
      input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
      output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
      input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
      input  ram_read_en_o, ram_write_en_o, ram_addr_o, ram_wdata_o,
      output ram_rdata_i, ram_err_i
   );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter
//  Shares one data RAM port between two requesters. One transaction is in
//  flight at a time: grant in IDLE, a single-cycle RAM enable in ACCESS, and a
//  one-cycle completion pulse to the owning port in RESP.
//  Ports:
//   clk_i    - clock, all state on the rising edge
//   rst_n_i  - asynchronous active-low reset
//   bus      - ram_arbiter_if.slave: m0/m1 request/response channels and the
//              RAM command/read-data port
//   busy_o   - high whenever the FSM is outside IDLE
//  Build option:
//   RAM_ARB_RR_EN - defined: round-robin on contention (port not granted last
//                   wins). Undefined: fixed priority, port 0 wins.
//
//  state     | meaning
//  ----------+---------------------------------------------------------------
//  ST_IDLE   | waiting for a request; grant is combinational from req
//  ST_ACCESS | RAM enabled for exactly this cycle with the latched command
//  ST_RESP   | RAM read data / error returned to the owner with rvalid
module ram_arbiter #(
   parameter int ADDR_W     = 64,
   parameter int DATA_W     = 64,
   parameter int ALIGN_BITS = 3
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   ram_arbiter_if.slave       bus,
   output logic               busy_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              misalign_q, misalign_d;

   logic              req_any;
   logic              sel1;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_misalign;
   logic              gnt0, gnt1;

   assign req_any = bus.m0_req_i | bus.m1_req_i;

`ifdef RAM_ARB_RR_EN
   // last_q = port granted most recently; on contention the other one wins.
   logic last_q, last_d;
   assign sel1 = bus.m1_req_i & (~bus.m0_req_i | ~last_q);
`else
   assign sel1 = bus.m1_req_i & ~bus.m0_req_i;
`endif

   assign sel_we    = sel1 ? bus.m1_we_i    : bus.m0_we_i;
   assign sel_addr  = sel1 ? bus.m1_addr_i  : bus.m0_addr_i;
   assign sel_wdata = sel1 ? bus.m1_wdata_i : bus.m0_wdata_i;

   generate
      if (ALIGN_BITS == 0) begin : g_no_align
         assign sel_misalign = 1'b0;
      end else begin : g_align
         assign sel_misalign = |sel_addr[ALIGN_BITS-1:0];
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      misalign_d = misalign_q;
      gnt0       = 1'b0;
      gnt1       = 1'b0;
`ifdef RAM_ARB_RR_EN
      last_d     = last_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req_any) begin
               gnt0       = ~sel1;
               gnt1       = sel1;
               owner_d    = sel1;
               we_d       = sel_we;
               addr_d     = sel_addr;
               wdata_d    = sel_wdata;
               misalign_d = sel_misalign;
`ifdef RAM_ARB_RR_EN
               last_d     = sel1;
`endif
               // A misaligned access never touches the RAM.
               state_d    = sel_misalign ? ST_RESP : ST_ACCESS;
            end
         end
         ST_ACCESS: state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         misalign_q <= misalign_d;
      end
   end

`ifdef RAM_ARB_RR_EN
   // Reset points at port 1 so port 0 wins the first contention.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`endif

   // Grant is combinational from req, so it is masked while reset is held to
   // keep every output low during reset.
   assign bus.m0_gnt_o = gnt0 & rst_n_i;
   assign bus.m1_gnt_o = gnt1 & rst_n_i;

   // Enables decode straight from the state register, so they fall as soon as
   // reset asserts. Address/data hold the latched command in every state.
   assign bus.ram_read_en_o  = (state_q == ST_ACCESS) & ~we_q;
   assign bus.ram_write_en_o = (state_q == ST_ACCESS) & we_q;
   assign bus.ram_addr_o     = addr_q;
   assign bus.ram_wdata_o    = wdata_q;

   logic              resp_active;
   logic              rvalid0, rvalid1;
   logic              resp_err;
   logic [DATA_W-1:0] resp_rdata;

   assign resp_active = (state_q == ST_RESP);
   assign rvalid0     = resp_active & ~owner_q;
   assign rvalid1     = resp_active & owner_q;
   assign resp_err    = bus.ram_err_i | misalign_q;
   assign resp_rdata  = (~we_q & ~resp_err) ? bus.ram_rdata_i : '0;

   assign bus.m0_rvalid_o = rvalid0;
   assign bus.m0_rdata_o  = rvalid0 ? resp_rdata : '0;
   assign bus.m0_err_o    = rvalid0 & resp_err;
   assign bus.m1_rvalid_o = rvalid1;
   assign bus.m1_rdata_o  = rvalid1 ? resp_rdata : '0;
   assign bus.m1_err_o    = rvalid1 & resp_err;

   assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//  Self-checking bench for ram_arbiter. A small RAM model answers the RAM
//  port; a reference memory and a per-scenario arbitration model supply every
//  expected value. Inputs change 1 time unit after a rising edge; a monitor
//  samples outputs 2 units before the next rising edge.
`timescale 1ns/1ps
module tb_ram_arbiter;
   localparam int AW = 64;
   localparam int DW = 64;
`ifdef RAM_ARB_RR_EN
   localparam bit RR_MODE = 1'b1;
`else
   localparam bit RR_MODE = 1'b0;
`endif

   logic clk;
   logic rst_n;
   logic busy;

   ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ALIGN_BITS(3)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus),
      .busy_o  (busy)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   int model_last = 1;   // port granted last, as the bench expects it
   logic err_inject = 1'b0;
   logic [63:0] ref_mem [64];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // RAM model: read data and error appear the cycle after the enable.
   logic [63:0] mem [64];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.ram_rdata_i <= '0;
         bus.ram_err_i   <= 1'b0;
         for (int i = 0; i < 64; i++) mem[i] <= '0;
      end else begin
         bus.ram_err_i <= 1'b0;
         if (bus.ram_write_en_o) mem[bus.ram_addr_o[8:3]] <= bus.ram_wdata_o;
         if (bus.ram_read_en_o) begin
            bus.ram_rdata_i <= mem[bus.ram_addr_o[8:3]];
            bus.ram_err_i   <= err_inject;
         end
      end
   end

   // Monitor
   int cyc = 0;
   int g_cnt[2]  = '{0, 0};
   int g_cyc[2]  = '{0, 0};
   int rv_cnt[2] = '{0, 0};
   int rv_cyc[2] = '{0, 0};
   logic [63:0] rv_data[2];
   logic        rv_err[2];
   int ren_cnt = 0, wen_cnt = 0, viol = 0, junk = 0;
   logic [63:0] wen_addr, wen_data;
   int glog[$];
   logic [63:0] rvq0[$], rvq1[$];

   always begin
      @(posedge clk);
      #8;
      cyc++;
      if (bus.ram_read_en_o) ren_cnt++;
      if (bus.ram_write_en_o) begin
         wen_cnt++;
         wen_addr = bus.ram_addr_o;
         wen_data = bus.ram_wdata_o;
      end
      if (bus.ram_read_en_o && bus.ram_write_en_o) viol++;
      if (bus.m0_gnt_o && bus.m1_gnt_o) viol++;
      if (bus.m0_rvalid_o && bus.m1_rvalid_o) viol++;
      if ((bus.m0_gnt_o || bus.m1_gnt_o) && busy) viol++;
      if ((bus.m0_gnt_o && !bus.m0_req_i) || (bus.m1_gnt_o && !bus.m1_req_i)) viol++;
      if (!bus.m0_rvalid_o && (bus.m0_rdata_o != 0 || bus.m0_err_o)) junk++;
      if (!bus.m1_rvalid_o && (bus.m1_rdata_o != 0 || bus.m1_err_o)) junk++;
      if (bus.m0_gnt_o) begin g_cnt[0]++; g_cyc[0] = cyc; glog.push_back(0); end
      if (bus.m1_gnt_o) begin g_cnt[1]++; g_cyc[1] = cyc; glog.push_back(1); end
      if (bus.m0_rvalid_o) begin
         rv_cnt[0]++; rv_cyc[0] = cyc; rv_data[0] = bus.m0_rdata_o; rv_err[0] = bus.m0_err_o;
         rvq0.push_back(bus.m0_rdata_o);
      end
      if (bus.m1_rvalid_o) begin
         rv_cnt[1]++; rv_cyc[1] = cyc; rv_data[1] = bus.m1_rdata_o; rv_err[1] = bus.m1_err_o;
         rvq1.push_back(bus.m1_rdata_o);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_cmd(input int p, input logic req, input logic we,
                          input logic [63:0] addr, input logic [63:0] wd);
      if (p == 0) begin
         bus.m0_req_i = req; bus.m0_we_i = we; bus.m0_addr_i = addr; bus.m0_wdata_i = wd;
      end else begin
         bus.m1_req_i = req; bus.m1_we_i = we; bus.m1_addr_i = addr; bus.m1_wdata_i = wd;
      end
   endtask

   // Single-port transaction; lat = rvalid cycle minus grant cycle.
   task automatic run_one(input int p, input logic we, input logic [63:0] addr,
                          input logic [63:0] wd, output int lat, output bit to);
      int g0, r0;
      bit got;
      g0 = g_cnt[p]; r0 = rv_cnt[p]; to = 1'b0; lat = -1;
      @(posedge clk); #1;
      set_cmd(p, 1'b1, we, addr, wd);
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (g_cnt[p] != g0) begin got = 1'b1; break; end
      end
      set_cmd(p, 1'b0, 1'b0, '0, '0);
      if (!got) begin to = 1'b1; return; end
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (rv_cnt[p] != r0) begin got = 1'b1; break; end
         @(posedge clk); #1;
      end
      if (!got) to = 1'b1;
      else lat = rv_cyc[p] - g_cyc[p];
   endtask

   task automatic clear_ref;
      for (int i = 0; i < 64; i++) ref_mem[i] = '0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      set_cmd(0, 1'b1, 1'b0, 64'h40, 64'h0);
      set_cmd(1, 1'b0, 1'b0, '0, '0);
      clear_ref();
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({busy, bus.m0_gnt_o, bus.m1_gnt_o, bus.m0_rvalid_o, bus.m1_rvalid_o, bus.m0_err_o,
           bus.m1_err_o, bus.ram_read_en_o, bus.ram_write_en_o} !== 9'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 0", {busy, bus.m0_gnt_o, bus.m1_gnt_o,
                  bus.m0_rvalid_o, bus.m1_rvalid_o, bus.m0_err_o, bus.m1_err_o,
                  bus.ram_read_en_o, bus.ram_write_en_o});
      end
      n_cmp++;
      if ((bus.ram_addr_o | bus.ram_wdata_o | bus.m0_rdata_o | bus.m1_rdata_o) !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h want 0",
                  bus.ram_addr_o | bus.ram_wdata_o | bus.m0_rdata_o | bus.m1_rdata_o);
      end
      set_cmd(0, 1'b0, 1'b0, '0, '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_last = 1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_write_read;
      int lat, w0, r0;
      bit to;
      w0 = wen_cnt; r0 = ren_cnt;
      run_one(0, 1'b1, 64'h10, 64'hDEAD_BEEF, lat, to);
      ref_mem[2] = 64'hDEAD_BEEF;
      n_cmp++;
      if (to || lat != 2) begin n_fail++; $display("FAIL wr_latency: got %0d (timeout %0d) want 2", lat, to); end
      n_cmp++;
      if (wen_cnt - w0 != 1 || ren_cnt != r0) begin
         n_fail++; $display("FAIL wr_enables: got wen %0d ren %0d want 1 0", wen_cnt - w0, ren_cnt - r0);
      end
      n_cmp++;
      if (wen_addr !== 64'h10 || wen_data !== 64'hDEAD_BEEF) begin
         n_fail++; $display("FAIL wr_ram_cmd: got %h/%h want 10/deadbeef", wen_addr, wen_data);
      end
      n_cmp++;
      if (rv_data[0] !== 64'h0 || rv_err[0] !== 1'b0) begin
         n_fail++; $display("FAIL wr_resp: got %h err %b want 0 err 0", rv_data[0], rv_err[0]);
      end
      w0 = wen_cnt;
      run_one(0, 1'b0, 64'h10, 64'h0, lat, to);
      n_cmp++;
      if (to || lat != 2) begin n_fail++; $display("FAIL rd_latency: got %0d (timeout %0d) want 2", lat, to); end
      n_cmp++;
      if (rv_data[0] !== 64'hDEAD_BEEF || rv_err[0] !== 1'b0) begin
         n_fail++; $display("FAIL rd_data: got %h err %b want deadbeef err 0", rv_data[0], rv_err[0]);
      end
      n_cmp++;
      if (ren_cnt - r0 != 1 || wen_cnt != w0) begin
         n_fail++; $display("FAIL rd_enables: got ren %0d wen %0d want 1 0", ren_cnt - r0, wen_cnt - w0);
      end
      model_last = 0;
   endtask

   task automatic test_random_single;
      int lat, p, idx;
      bit to;
      logic we;
      logic [63:0] d, exp_d;
      for (int n = 0; n < 10; n++) begin
         p = int'($urandom_range(0, 1));
         we = 1'($urandom_range(0, 1));
         idx = int'($urandom_range(0, 7));
         d = {$urandom, $urandom};
         exp_d = we ? 64'h0 : ref_mem[idx];
         run_one(p, we, 64'(idx * 8), d, lat, to);
         if (we) ref_mem[idx] = d;
         model_last = p;
         n_cmp++;
         if (to || lat != 2 || rv_data[p] !== exp_d || rv_err[p] !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_single[%0d]: got lat %0d data %h err %b want lat 2 data %h err 0",
                     n, lat, rv_data[p], rv_err[p], exp_d);
         end
      end
   endtask

   task automatic test_contention;
      int lat, base, exp_first, exp_second, got_first, gap;
      int g0[2], r0[2];
      bit to;
      bit done[2];
      run_one(1, 1'b1, 64'h08, {$urandom, 32'h1111_0000}, lat, to);
      ref_mem[1] = bus.m1_wdata_i;
      ref_mem[1] = (wen_addr == 64'h08) ? wen_data : ref_mem[1];
      run_one(0, 1'b1, 64'h18, {$urandom, 32'h2222_0000}, lat, to);
      ref_mem[3] = wen_data;
      model_last = 0;
      exp_first  = RR_MODE ? ((model_last == 0) ? 1 : 0) : 0;
      exp_second = 1 - exp_first;
      base = glog.size();
      g0 = g_cnt; r0 = rv_cnt; done = '{1'b0, 1'b0};
      @(posedge clk); #1;
      set_cmd(0, 1'b1, 1'b0, 64'h08, '0);
      set_cmd(1, 1'b1, 1'b0, 64'h18, '0);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         for (int p = 0; p < 2; p++) begin
            if (!done[p] && g_cnt[p] != g0[p]) begin
               done[p] = 1'b1;
               set_cmd(p, 1'b0, 1'b0, '0, '0);
            end
         end
         if (done[0] && done[1]) break;
      end
      set_cmd(0, 1'b0, 1'b0, '0, '0);
      set_cmd(1, 1'b0, 1'b0, '0, '0);
      repeat (4) @(posedge clk);
      #1;
      got_first = (glog.size() >= base + 2) ? glog[base] : -1;
      gap = g_cyc[exp_second] - g_cyc[exp_first];
      n_cmp++;
      if (got_first != exp_first) begin
         n_fail++; $display("FAIL cont_winner: got %0d want %0d", got_first, exp_first);
      end
      n_cmp++;
      if (!(done[0] && done[1]) || gap != 3) begin
         n_fail++; $display("FAIL cont_gap: got %0d want 3", gap);
      end
      n_cmp++;
      if (rv_cnt[0] - r0[0] != 1 || rv_cnt[1] - r0[1] != 1 ||
          rv_data[0] !== ref_mem[1] || rv_data[1] !== ref_mem[3]) begin
         n_fail++;
         $display("FAIL cont_data: got %h/%h want %h/%h", rv_data[0], rv_data[1], ref_mem[1], ref_mem[3]);
      end
      model_last = exp_second;
   endtask

   task automatic test_back_to_back;
      int rem[2], g0[2];
      int exp_seq[$];
      int last, w, base, idx;
      logic cw[2];
      logic [63:0] ca[2], cd[2];
      logic [63:0] expq0[$], expq1[$];
      rem = '{4, 4};
      last = model_last;
      for (int k = 0; k < 8; k++) begin
         if (rem[0] > 0 && rem[1] > 0) w = RR_MODE ? ((last == 0) ? 1 : 0) : 0;
         else w = (rem[0] > 0) ? 0 : 1;
         exp_seq.push_back(w);
         rem[w]--;
         last = w;
      end
      rem = '{4, 4};
      rvq0.delete(); rvq1.delete();
      base = glog.size();
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
         cw[p] = 1'($urandom_range(0, 1));
         ca[p] = {58'd0, 3'($urandom_range(0, 7)), 3'b000};
         cd[p] = {$urandom, $urandom};
         set_cmd(p, 1'b1, cw[p], ca[p], cd[p]);
      end
      g0 = g_cnt;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         for (int p = 0; p < 2; p++) begin
            if (g_cnt[p] != g0[p]) begin
               g0[p] = g_cnt[p];
               idx = int'(ca[p][5:3]);
               if (p == 0) expq0.push_back(cw[p] ? 64'h0 : ref_mem[idx]);
               else        expq1.push_back(cw[p] ? 64'h0 : ref_mem[idx]);
               if (cw[p]) ref_mem[idx] = cd[p];
               rem[p]--;
               if (rem[p] == 0) begin
                  set_cmd(p, 1'b0, 1'b0, '0, '0);
               end else begin
                  cw[p] = 1'($urandom_range(0, 1));
                  ca[p] = {58'd0, 3'($urandom_range(0, 7)), 3'b000};
                  cd[p] = {$urandom, $urandom};
                  set_cmd(p, 1'b1, cw[p], ca[p], cd[p]);
               end
            end
         end
         if (rem[0] == 0 && rem[1] == 0) break;
      end
      set_cmd(0, 1'b0, 1'b0, '0, '0);
      set_cmd(1, 1'b0, 1'b0, '0, '0);
      repeat (4) @(posedge clk);
      #1;
      n_cmp++;
      if (glog.size() != base + 8) begin
         n_fail++; $display("FAIL b2b_grants: got %0d want 8", glog.size() - base);
      end
      for (int k = 0; k < 8; k++) begin
         n_cmp++;
         if (((glog.size() > base + k) ? glog[base + k] : -1) != exp_seq[k]) begin
            n_fail++;
            $display("FAIL b2b_order[%0d]: got %0d want %0d", k,
                     (glog.size() > base + k) ? glog[base + k] : -1, exp_seq[k]);
         end
      end
      n_cmp++;
      if (rvq0.size() != expq0.size() || rvq1.size() != expq1.size() || expq0.size() != 4) begin
         n_fail++;
         $display("FAIL b2b_resp_count: got %0d/%0d want 4/4", rvq0.size(), rvq1.size());
      end
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if ((k < rvq0.size() && k < expq0.size() && rvq0[k] !== expq0[k]) ||
             (k < rvq1.size() && k < expq1.size() && rvq1[k] !== expq1[k])) begin
            n_fail++;
            $display("FAIL b2b_data[%0d]: got %h/%h want %h/%h", k,
                     (k < rvq0.size()) ? rvq0[k] : 64'h0, (k < rvq1.size()) ? rvq1[k] : 64'h0,
                     (k < expq0.size()) ? expq0[k] : 64'h0, (k < expq1.size()) ? expq1[k] : 64'h0);
         end
      end
      model_last = exp_seq[7];
   endtask

   task automatic test_misalign;
      int lat, r0, w0;
      bit to;
      r0 = ren_cnt; w0 = wen_cnt;
      run_one(0, 1'b0, 64'h0C, '0, lat, to);
      n_cmp++;
      if (to || lat != 1) begin n_fail++; $display("FAIL mis_latency: got %0d (timeout %0d) want 1", lat, to); end
      n_cmp++;
      if (rv_err[0] !== 1'b1 || rv_data[0] !== 64'h0) begin
         n_fail++; $display("FAIL mis_resp: got err %b data %h want 1 0", rv_err[0], rv_data[0]);
      end
      run_one(1, 1'b1, 64'h21, {$urandom, $urandom}, lat, to);
      n_cmp++;
      if (to || lat != 1 || rv_err[1] !== 1'b1) begin
         n_fail++; $display("FAIL mis_write: got lat %0d err %b want 1 1", lat, rv_err[1]);
      end
      n_cmp++;
      if (ren_cnt != r0 || wen_cnt != w0) begin
         n_fail++; $display("FAIL mis_no_ram: got ren %0d wen %0d want 0 0", ren_cnt - r0, wen_cnt - w0);
      end
      model_last = 1;
   endtask

   task automatic test_ram_error;
      int lat, rv0, j0;
      bit to;
      logic [63:0] d;
      d = {$urandom, $urandom} | 64'h1;
      run_one(1, 1'b1, 64'h30, d, lat, to);
      ref_mem[6] = d;
      rv0 = rv_cnt[0]; j0 = junk;
      err_inject = 1'b1;
      run_one(1, 1'b0, 64'h30, '0, lat, to);
      err_inject = 1'b0;
      n_cmp++;
      if (to || rv_err[1] !== 1'b1 || rv_data[1] !== 64'h0) begin
         n_fail++; $display("FAIL ramerr_resp: got err %b data %h want 1 0", rv_err[1], rv_data[1]);
      end
      n_cmp++;
      if (rv_cnt[0] != rv0 || junk != j0) begin
         n_fail++; $display("FAIL ramerr_m0: got rvalid %0d junk %0d want 0 0", rv_cnt[0] - rv0, junk - j0);
      end
      // The same location reads back cleanly once the error goes away.
      run_one(1, 1'b0, 64'h30, '0, lat, to);
      n_cmp++;
      if (to || rv_err[1] !== 1'b0 || rv_data[1] !== d) begin
         n_fail++; $display("FAIL ramerr_recover: got err %b data %h want 0 %h", rv_err[1], rv_data[1], d);
      end
      model_last = 1;
   endtask

   task automatic test_mid_reset;
      int r0, g0, base;
      bit got;
      r0 = rv_cnt[0]; g0 = g_cnt[0];
      @(posedge clk); #1;
      set_cmd(0, 1'b1, 1'b0, 64'h10, '0);
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (g_cnt[0] != g0) begin got = 1'b1; break; end
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (!got || {busy, bus.m0_gnt_o, bus.m1_gnt_o, bus.m0_rvalid_o, bus.m1_rvalid_o,
                   bus.ram_read_en_o, bus.ram_write_en_o} !== 7'b0) begin
         n_fail++;
         $display("FAIL midrst_async: got busy %b ren %b gnt %b want 0 0 0 (granted %0d)",
                  busy, bus.ram_read_en_o, bus.m0_gnt_o, got);
      end
      n_cmp++;
      if ((bus.ram_addr_o | bus.m0_rdata_o) !== 64'h0) begin
         n_fail++; $display("FAIL midrst_regs: got %h want 0", bus.ram_addr_o | bus.m0_rdata_o);
      end
      set_cmd(0, 1'b0, 1'b0, '0, '0);
      clear_ref();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      n_cmp++;
      if (rv_cnt[0] != r0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL midrst_no_rvalid: got %0d rvalid busy %b want 0 0", rv_cnt[0] - r0, busy);
      end
      model_last = 1;
      // Contention right after reset: port 0 wins in either mode.
      base = glog.size();
      set_cmd(0, 1'b1, 1'b1, 64'h38, 64'h5);
      set_cmd(1, 1'b1, 1'b1, 64'h28, 64'h6);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (glog.size() > base) set_cmd(glog[base], 1'b0, 1'b0, '0, '0);
         if (glog.size() > base + 1) break;
      end
      set_cmd(0, 1'b0, 1'b0, '0, '0);
      set_cmd(1, 1'b0, 1'b0, '0, '0);
      repeat (4) @(posedge clk);
      #1;
      n_cmp++;
      if (((glog.size() > base) ? glog[base] : -1) != 0) begin
         n_fail++; $display("FAIL midrst_first_winner: got %0d want 0", (glog.size() > base) ? glog[base] : -1);
      end
   endtask

   task automatic test_protocol;
      n_cmp++;
      if (viol != 0) begin n_fail++; $display("FAIL protocol_violations: got %0d want 0", viol); end
      n_cmp++;
      if (junk != 0) begin n_fail++; $display("FAIL idle_outputs_nonzero: got %0d want 0", junk); end
   endtask

   initial begin
      set_cmd(0, 1'b0, 1'b0, '0, '0);
      set_cmd(1, 1'b0, 1'b0, '0, '0);
      test_reset();
      test_write_read();
      test_random_single();
      test_contention();
      test_back_to_back();
      test_misalign();
      test_ram_error();
      test_mid_reset();
      test_protocol();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
